su_adder_drain: RTL and testbench

- Spatial-unit adder/drain stage directly downstream of the per-PE psum double-buffer RFs.
- After a buffer swap, it sweeps the idle (non-MAC) buffer of every PE through the shared address bus and sums the NUM_PE psums element-wise.
- It then writes each reduced result to the global buffer over a valid/ready handshake.
- Runs concurrently with MAC use of the other buffer.

---
 rtl/su_adder_drain.sv | 196 +++++++++++++++++++
 tb/tb_su_adder_drain.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/su_adder_drain.sv
// su_adder_drain: spatial-unit adder/drain stage.
// Sweeps the idle psum buffer of every PE over a shared RF address bus. The
// NUM_PE psums of each entry are summed, and each result is written to the
// global buffer over a valid/ready handshake through a 2-entry output FIFO.
// Optional feature macro: SU_SAT_EN. When it is defined, results saturate to
// the signed DATA_BITWIDTH range. When it is undefined, results wrap.
module su_adder_drain #(
   parameter int unsigned DATA_BITWIDTH    = 16,
   parameter int unsigned ADDR_BITWIDTH    = 2,
   parameter int unsigned DEPTH            = 4,
   parameter int unsigned NUM_PE           = 4,
   parameter int unsigned GB_ADDR_BITWIDTH = 10
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               en1,
   input  logic                               start,
   input  logic [GB_ADDR_BITWIDTH-1:0]        gb_base,
   input  logic [NUM_PE*DATA_BITWIDTH-1:0]    psum_in1,
   input  logic [NUM_PE*DATA_BITWIDTH-1:0]    psum_in2,
   output logic [ADDR_BITWIDTH-1:0]           su_addr,
   output logic                               gb_w_valid,
   input  logic                               gb_w_ready,
   output logic [DATA_BITWIDTH-1:0]           gb_w_data,
   output logic [GB_ADDR_BITWIDTH-1:0]        gb_w_addr,
   output logic                               busy,
   output logic                               done,
   output logic                               abort
);

   // The low DATA_BITWIDTH bits of the exact sum equal a DATA_BITWIDTH-wide
   // modular sum. The accumulator is widened only when saturation needs the
   // extra bits.
`ifdef SU_SAT_EN
   localparam int unsigned ACC_W = DATA_BITWIDTH + $clog2(NUM_PE);
`else
   localparam int unsigned ACC_W = DATA_BITWIDTH;
`endif
   localparam logic [ADDR_BITWIDTH-1:0] LAST_IDX = ADDR_BITWIDTH'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_FLUSH
   } state_t;

   state_t                        state_q;
   logic                          sel_q;
   logic [GB_ADDR_BITWIDTH-1:0]   base_q;
   logic [GB_ADDR_BITWIDTH-1:0]   out_idx_q;
   logic [ADDR_BITWIDTH-1:0]      idx_q;
   logic [ADDR_BITWIDTH-1:0]      addr_q;
   logic                          inflight_q;
   logic [DATA_BITWIDTH-1:0]      fifo_q [2];
   logic                          wr_ptr_q;
   logic                          rd_ptr_q;
   logic [1:0]                    cnt_q;
   logic                          busy_q;
   logic                          done_q;
   logic                          abort_q;

   logic                          kill;
   logic                          pop;
   logic                          push;
   logic                          issue;
   logic [1:0]                    cnt_drain;
   logic [2:0]                    occ;
   logic [1:0]                    cnt_d;

   logic [NUM_PE*DATA_BITWIDTH-1:0] rd_data;
   logic signed [DATA_BITWIDTH-1:0] pe_val;
   logic signed [ACC_W-1:0]         sum_full;
   logic [DATA_BITWIDTH-1:0]        sum_out;

   // A change of en1 during a sweep means the drained buffer is being reused.
   assign kill      = (state_q != S_IDLE) && (en1 != sel_q);
   assign pop       = gb_w_valid && gb_w_ready;
   assign push      = inflight_q;
   // Credit counts the slot freed by a pop in this same cycle.
   // Without that, a ready sink could not reach one result per cycle.
   assign cnt_drain = cnt_q - {1'b0, pop};
   assign occ       = {1'b0, cnt_drain} + {2'b00, inflight_q};
   assign issue     = (state_q == S_ISSUE) && !kill && (occ < 3'd2);
   assign cnt_d     = cnt_drain + {1'b0, push};

   assign su_addr    = issue ? idx_q : addr_q;
   assign gb_w_valid = (cnt_q != 2'd0);
   assign gb_w_data  = fifo_q[rd_ptr_q];
   assign gb_w_addr  = base_q + out_idx_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign abort      = abort_q;

   // Sign-extending adder across the selected buffer's PE read data.
   always_comb begin
      rd_data  = sel_q ? psum_in2 : psum_in1;
      sum_full = '0;
      pe_val   = '0;
      for (int unsigned k = 0; k < NUM_PE; k++) begin
         pe_val   = signed'(rd_data[k*DATA_BITWIDTH +: DATA_BITWIDTH]);
         sum_full = sum_full + ACC_W'(pe_val);
      end
   end

`ifdef SU_SAT_EN
   // Clamp the exact sum to the signed output range.
   always_comb begin
      if (sum_full[ACC_W-1:DATA_BITWIDTH-1] ==
          {(ACC_W-DATA_BITWIDTH+1){sum_full[ACC_W-1]}}) begin
         sum_out = sum_full[DATA_BITWIDTH-1:0];
      end else if (sum_full[ACC_W-1]) begin
         sum_out = {1'b1, {(DATA_BITWIDTH-1){1'b0}}};
      end else begin
         sum_out = {1'b0, {(DATA_BITWIDTH-1){1'b1}}};
      end
   end
`else
   assign sum_out = sum_full;
`endif

   // Sweep control FSM, read-issue credit tracking, and the output FIFO.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         sel_q      <= 1'b0;
         base_q     <= '0;
         out_idx_q  <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         fifo_q     <= '{default: '0};
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         if (issue) begin
            addr_q <= idx_q;
         end
         if (kill) begin
            abort_q    <= 1'b1;
            busy_q     <= 1'b0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            state_q    <= S_IDLE;
         end else begin
            inflight_q <= issue;
            if (push) begin
               fifo_q[wr_ptr_q] <= sum_out;
               wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
               rd_ptr_q  <= ~rd_ptr_q;
               out_idx_q <= out_idx_q + 1'b1;
            end
            cnt_q <= cnt_d;
            unique case (state_q)
               S_IDLE: begin
                  if (start) begin
                     sel_q     <= en1;
                     base_q    <= gb_base;
                     idx_q     <= '0;
                     out_idx_q <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (issue) begin
                     if (idx_q == LAST_IDX) begin
                        state_q <= S_FLUSH;
                     end else begin
                        idx_q <= idx_q + 1'b1;
                     end
                  end
               end
               S_FLUSH: begin
                  if (!inflight_q && (cnt_drain == 2'd0)) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_su_adder_drain.sv
// Self-checking bench for su_adder_drain.
// A behavioural RF model has one-cycle read latency.
// A scoreboard queue holds the expected GB writes.
module tb_su_adder_drain;

   localparam int W = 16;
   localparam int A = 2;
   localparam int D = 4;
   localparam int N = 4;
   localparam int G = 10;

   logic             clk = 1'b0;
   logic             reset;
   logic             en1;
   logic             start;
   logic [G-1:0]     gb_base;
   logic [N*W-1:0]   psum_in1;
   logic [N*W-1:0]   psum_in2;
   logic [A-1:0]     su_addr;
   logic             gb_w_valid;
   logic             gb_w_ready;
   logic [W-1:0]     gb_w_data;
   logic [G-1:0]     gb_w_addr;
   logic             busy;
   logic             done;
   logic             abort;

   typedef struct {
      logic [W-1:0] d;
      logic [G-1:0] a;
   } exp_t;

   exp_t          sbq[$];
   exp_t          mon_e;
   int            vectors = 0;
   int            miscompares = 0;
   logic [W-1:0]  rf1 [N][D];
   logic [W-1:0]  rf2 [N][D];
   logic [A-1:0]  addr_log [0:40];
   logic [W-1:0]  last_data;
   logic          pv;
   logic          pr;
   logic [W-1:0]  pd;
   logic [G-1:0]  pa;

   su_adder_drain #(
      .DATA_BITWIDTH   (W),
      .ADDR_BITWIDTH   (A),
      .DEPTH           (D),
      .NUM_PE          (N),
      .GB_ADDR_BITWIDTH(G)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en1       (en1),
      .start     (start),
      .gb_base   (gb_base),
      .psum_in1  (psum_in1),
      .psum_in2  (psum_in2),
      .su_addr   (su_addr),
      .gb_w_valid(gb_w_valid),
      .gb_w_ready(gb_w_ready),
      .gb_w_data (gb_w_data),
      .gb_w_addr (gb_w_addr),
      .busy      (busy),
      .done      (done),
      .abort     (abort)
   );

   always #5 clk = ~clk;

   // Registered RF read port model for both buffers of every PE.
   always @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         psum_in1[k*W +: W] <= rf1[k][su_addr];
         psum_in2[k*W +: W] <= rf2[k][su_addr];
      end
   end

   function automatic logic [W-1:0] model_sum(input logic s, input int i);
      int acc;
      logic signed [W-1:0] v;
      acc = 0;
      for (int k = 0; k < N; k++) begin
         v   = s ? rf2[k][i] : rf1[k][i];
         acc = acc + int'(v);
      end
`ifdef SU_SAT_EN
      if (acc > 32767) return 16'h7FFF;
      if (acc < -32768) return 16'h8000;
`endif
      return 16'(acc);
   endfunction

   // Scoreboard check of each GB handshake, plus a hold check under backpressure.
   always @(negedge clk) begin
      if (reset) begin
         if (gb_w_valid && gb_w_ready) begin
            vectors++;
            if (sbq.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_xfer: got data=%h addr=%0d, required no transfer", gb_w_data, gb_w_addr);
            end else begin
               mon_e = sbq.pop_front();
               if (gb_w_data !== mon_e.d || gb_w_addr !== mon_e.a) begin
                  miscompares++;
                  $display("FAIL gb_write: got data=%h addr=%0d, required data=%h addr=%0d", gb_w_data, gb_w_addr, mon_e.d, mon_e.a);
               end
            end
            last_data = gb_w_data;
         end
         if (pv && !pr && !abort) begin
            vectors++;
            if (gb_w_valid !== 1'b1 || gb_w_data !== pd || gb_w_addr !== pa) begin
               miscompares++;
               $display("FAIL hold_stable: got v=%b data=%h addr=%0d, required v=1 data=%h addr=%0d", gb_w_valid, gb_w_data, gb_w_addr, pd, pa);
            end
         end
         pv = gb_w_valid;
         pr = gb_w_ready;
         pd = gb_w_data;
         pa = gb_w_addr;
      end else begin
         pv = 1'b0;
         pr = 1'b0;
      end
   end

   task automatic load_bufs(input int mode);
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < D; i++) begin
            case (mode)
               0: begin rf2[k][i] = 16'(10*k + i); rf1[k][i] = 16'($urandom); end
               1: begin rf1[k][i] = 16'(300*k + 17*i - 700); rf2[k][i] = 16'($urandom); end
               2: begin rf1[k][i] = 16'h7FFF; rf2[k][i] = 16'h7FFF; end
               3: begin rf1[k][i] = 16'h8000; rf2[k][i] = 16'h8000; end
               default: begin rf1[k][i] = 16'($urandom); rf2[k][i] = 16'($urandom); end
            endcase
         end
      end
   endtask

   task automatic push_expected(input logic s, input logic [G-1:0] base);
      exp_t e;
      for (int i = 0; i < D; i++) begin
         e.d = model_sum(s, i);
         e.a = G'(int'(base) + i);
         sbq.push_back(e);
      end
   endtask

   // Start one sweep in cycle 0 and trace it cycle by cycle until done.
   task automatic run_sweep(input logic en, input logic [G-1:0] base, input int bp_lo,
                            input int bp_hi, input int restart_t,
                            output int first_v, output int done_t, output int n_done);
      @(posedge clk); #1;
      en1 = en; gb_base = base; start = 1'b1; gb_w_ready = 1'b1;
      push_expected(en, base);
      first_v = -1; done_t = -1; n_done = 0;
      for (int t = 1; t <= 40; t++) begin
         @(posedge clk); #1;
         start      = (t == restart_t);
         gb_base    = (t == restart_t) ? 10'd500 : base;
         gb_w_ready = !(t >= bp_lo && t <= bp_hi);
         #1;
         addr_log[t] = su_addr;
         if (gb_w_valid && first_v < 0) first_v = t;
         if (done) begin
            n_done++;
            if (done_t < 0) done_t = t;
         end
         if (done_t >= 0) break;
      end
      start = 1'b0; gb_w_ready = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0; en1 = 1'b0; start = 1'b0; gb_base = '0; gb_w_ready = 1'b0;
      load_bufs(4);
      #2;
      vectors++;
      if ({gb_w_valid, busy, done, abort} !== 4'b0000 || su_addr !== '0) begin
         miscompares++;
         $display("FAIL reset_ctrl: got v/busy/done/abort=%b%b%b%b su_addr=%0d, required 0000 0", gb_w_valid, busy, done, abort, su_addr);
      end
      vectors++;
      if (gb_w_data !== '0 || gb_w_addr !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got data=%h addr=%0d, required 0 0", gb_w_data, gb_w_addr);
      end
      repeat (3) @(posedge clk);
      #3; reset = 1'b1;
   endtask

   task automatic test_basic_drain;
      int fv, dt, nd;
      load_bufs(0);
      run_sweep(1'b1, 10'd100, 99, 0, 0, fv, dt, nd);
      vectors++;
      if (fv !== 3) begin miscompares++; $display("FAIL basic_first_valid: got cycle %0d, required 3", fv); end
      vectors++;
      if (dt !== 7) begin miscompares++; $display("FAIL basic_done_cycle: got cycle %0d, required 7", dt); end
      vectors++;
      if (nd !== 1) begin miscompares++; $display("FAIL basic_done_count: got %0d, required 1", nd); end
      for (int t = 1; t <= 4; t++) begin
         vectors++;
         if (addr_log[t] !== A'(t - 1)) begin
            miscompares++;
            $display("FAIL basic_su_addr: cycle %0d got %0d, required %0d", t, addr_log[t], t - 1);
         end
      end
      vectors++;
      if (last_data !== 16'd72) begin miscompares++; $display("FAIL basic_last_data: got %0d, required 72", last_data); end
      vectors++;
      if (sbq.size() !== 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_drained: got %0d pending busy=%b, required 0 pending busy=0", sbq.size(), busy);
      end
   endtask

   task automatic test_buffer_select;
      int fv, dt, nd;
      load_bufs(1);
      run_sweep(1'b0, 10'd40, 99, 0, 0, fv, dt, nd);
      vectors++;
      if (nd !== 1 || sbq.size() !== 0) begin
         miscompares++;
         $display("FAIL bufsel_complete: got done=%0d pending=%0d, required 1 0", nd, sbq.size());
      end
      vectors++;
      if (last_data !== model_sum(1'b0, D - 1)) begin
         miscompares++;
         $display("FAIL bufsel_last: got %h, required %h", last_data, model_sum(1'b0, D - 1));
      end
   endtask

   task automatic test_backpressure;
      int fv, dt, nd;
      load_bufs(0);
      run_sweep(1'b1, 10'd100, 4, 8, 0, fv, dt, nd);
      for (int t = 4; t <= 8; t++) begin
         vectors++;
         if (addr_log[t] !== 2'd2) begin
            miscompares++;
            $display("FAIL bp_stall_addr: cycle %0d got %0d, required 2", t, addr_log[t]);
         end
      end
      vectors++;
      if (addr_log[9] !== 2'd3) begin miscompares++; $display("FAIL bp_resume_addr: got %0d, required 3", addr_log[9]); end
      vectors++;
      if (nd !== 1 || sbq.size() !== 0) begin
         miscompares++;
         $display("FAIL bp_complete: got done=%0d pending=%0d, required 1 0", nd, sbq.size());
      end
   endtask

   task automatic test_saturation;
      int fv, dt, nd;
      logic [W-1:0] want_hi, want_lo;
`ifdef SU_SAT_EN
      want_hi = 16'h7FFF; want_lo = 16'h8000;
`else
      want_hi = 16'hFFFC; want_lo = 16'h0000;
`endif
      load_bufs(2);
      run_sweep(1'b1, 10'd8, 99, 0, 0, fv, dt, nd);
      vectors++;
      if (last_data !== want_hi || sbq.size() !== 0) begin
         miscompares++;
         $display("FAIL sat_pos: got %h pending=%0d, required %h 0", last_data, sbq.size(), want_hi);
      end
      load_bufs(3);
      run_sweep(1'b0, 10'd16, 99, 0, 0, fv, dt, nd);
      vectors++;
      if (last_data !== want_lo || sbq.size() !== 0) begin
         miscompares++;
         $display("FAIL sat_neg: got %h pending=%0d, required %h 0", last_data, sbq.size(), want_lo);
      end
   endtask

   task automatic test_abort;
      int fv, dt, nd, n_done, n_valid, n_abort;
      load_bufs(4);
      @(posedge clk); #1;
      en1 = 1'b1; gb_base = 10'd50; start = 1'b1; gb_w_ready = 1'b1;
      push_expected(1'b1, 10'd50);
      n_done = 0; n_valid = 0; n_abort = 0;
      for (int t = 1; t <= 12; t++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (t == 2) en1 = 1'b0;
         #1;
         if (t == 3) begin
            vectors++;
            if ({abort, gb_w_valid, busy} !== 3'b100) begin
               miscompares++;
               $display("FAIL abort_pulse: got abort/valid/busy=%b%b%b, required 100", abort, gb_w_valid, busy);
            end
         end else if (abort) n_abort++;
         if (done) n_done++;
         if (gb_w_valid) n_valid++;
      end
      vectors++;
      if (n_done !== 0 || n_valid !== 0 || n_abort !== 0) begin
         miscompares++;
         $display("FAIL abort_quiet: got done=%0d valid=%0d extra_abort=%0d, required 0 0 0", n_done, n_valid, n_abort);
      end
      sbq.delete();
      run_sweep(1'b0, 10'd200, 99, 0, 0, fv, dt, nd);
      vectors++;
      if (fv !== 3 || dt !== 7 || sbq.size() !== 0) begin
         miscompares++;
         $display("FAIL abort_recover: got first=%0d done=%0d pending=%0d, required 3 7 0", fv, dt, sbq.size());
      end
   endtask

   task automatic test_back_to_back;
      int fv, dt, nd;
      load_bufs(4);
      run_sweep(1'b1, 10'd300, 99, 0, 2, fv, dt, nd);
      vectors++;
      if (nd !== 1 || dt !== 7 || sbq.size() !== 0) begin
         miscompares++;
         $display("FAIL b2b_first: got done=%0d at %0d pending=%0d, required 1 at 7, 0", nd, dt, sbq.size());
      end
      run_sweep(1'b1, 10'd1022, 99, 0, 0, fv, dt, nd);
      vectors++;
      if (fv !== 3 || dt !== 7 || sbq.size() !== 0) begin
         miscompares++;
         $display("FAIL b2b_wrap: got first=%0d done=%0d pending=%0d, required 3 7 0", fv, dt, sbq.size());
      end
   endtask

   task automatic test_async_reset;
      int fv, dt, nd;
      load_bufs(0);
      @(posedge clk); #1;
      en1 = 1'b1; gb_base = 10'd100; start = 1'b1; gb_w_ready = 1'b1;
      push_expected(1'b1, 10'd100);
      for (int t = 1; t <= 5; t++) begin
         @(posedge clk); #1;
         start = 1'b0;
      end
      #1;
      vectors++;
      if (gb_w_valid !== 1'b1 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_precond: got valid=%b busy=%b, required 1 1", gb_w_valid, busy);
      end
      #1; reset = 1'b0;
      #1;
      vectors++;
      if ({gb_w_valid, busy, done} !== 3'b000 || su_addr !== '0) begin
         miscompares++;
         $display("FAIL rst_async: got valid/busy/done=%b%b%b su_addr=%0d, required 000 0", gb_w_valid, busy, done, su_addr);
      end
      sbq.delete();
      @(posedge clk); #3; reset = 1'b1;
      run_sweep(1'b1, 10'd100, 99, 0, 0, fv, dt, nd);
      vectors++;
      if (fv !== 3 || dt !== 7 || nd !== 1 || sbq.size() !== 0) begin
         miscompares++;
         $display("FAIL rst_recover: got first=%0d done=%0d n=%0d pending=%0d, required 3 7 1 0", fv, dt, nd, sbq.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic_drain();
      test_buffer_select();
      test_backpressure();
      test_saturation();
      test_abort();
      test_back_to_back();
      test_async_reset();
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      miscompares++;
      $display("FAIL watchdog: got no completion by 100000, required completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog expired");
   end

endmodule
